// File: rtl/swd_memap_seq.sv
// swd_memap_seq: turns single 32-bit MEM-AP accesses into ADIv5 register commands.
// DP SELECT, AP CSW and AP TAR are cached so that redundant register writes are skipped.
module swd_memap_seq #(
  parameter logic [31:0] CSW_BASE = 32'h2300_0000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WRITE,
  input  logic [7:0]  REQ_APSEL,
  input  logic [1:0]  REQ_SIZE,
  input  logic [31:0] REQ_ADDR,
  input  logic [31:0] REQ_WDATA,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic [31:0] RSP_RDATA,
  output logic [2:0]  RSP_STAT,
  output logic [39:0] CMD_WRDATA,
  output logic        CMD_WREN,
  input  logic        CMD_WRFULL,
  input  logic [34:0] ST_RDDATA,
  output logic        ST_RDEN,
  input  logic        ST_RDEMPTY
);

  typedef enum logic [2:0] {IDLE, SEL, CSW, TAR, DRW, RDBUF, WAIT, RESP} state_t;

  localparam logic [2:0] STAT_OK = 3'b100;

  state_t      state_q, state_d, step_q;
  logic        pend_q;
  logic        req_write_q;
  logic [7:0]  req_apsel_q;
  logic [1:0]  req_size_q;
  logic [31:0] req_addr_q;
  logic [31:0] req_wdata_q;
  logic        sel_v, csw_v, tar_v;
  logic [7:0]  sel_ap;
  logic [1:0]  csw_sz;
  logic [31:0] tar;
  logic [31:0] rsp_rdata_q;
  logic [2:0]  rsp_stat_q;
  logic        accept, sample, stat_ok;
  logic        sel_hit, csw_hit, tar_hit;
  logic [7:0]  cur_ap;
  logic [1:0]  cur_sz;
  logic [31:0] cur_addr;
  logic [39:0] cmd_word;

  // In IDLE the hit checks look at the live request so the first step is chosen on accept.
  assign cur_ap   = (state_q == IDLE) ? REQ_APSEL : req_apsel_q;
  assign cur_sz   = (state_q == IDLE) ? REQ_SIZE  : req_size_q;
  assign cur_addr = (state_q == IDLE) ? REQ_ADDR  : req_addr_q;
  assign sel_hit  = sel_v && (sel_ap == cur_ap);
  assign csw_hit  = csw_v && (csw_sz == cur_sz);
  assign tar_hit  = tar_v && (tar == cur_addr);
  assign stat_ok  = (ST_RDDATA[2:0] == STAT_OK);

  assign RSP_RDATA = rsp_rdata_q;
  assign RSP_STAT  = rsp_stat_q;

  function automatic state_t next_step(input state_t from, input logic s_hit,
                                       input logic c_hit, input logic t_hit, input logic wr);
    if (from <= SEL && !s_hit) return SEL;
    if (from <= CSW && !c_hit) return CSW;
    if (from <= TAR && !t_hit) return TAR;
    if (from <= DRW) return DRW;
    if (from <= RDBUF && !wr) return RDBUF;
    return RESP;
  endfunction

  always_comb begin
    cmd_word = '0;
    case (state_q)
      SEL:     cmd_word = {req_apsel_q, 24'h0, 6'd2, 1'b0, 1'b0};
      CSW:     cmd_word = {CSW_BASE | {30'h0, req_size_q}, 6'd0, 1'b1, 1'b0};
      TAR:     cmd_word = {req_addr_q, 6'd1, 1'b1, 1'b0};
      DRW:     cmd_word = req_write_q ? {req_wdata_q, 6'd3, 1'b1, 1'b0}
                                      : {32'h0, 6'd3, 1'b1, 1'b1};
      RDBUF:   cmd_word = {32'h0, 6'd3, 1'b0, 1'b1};
      default: cmd_word = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    REQ_READY  = 1'b0;
    RSP_VALID  = 1'b0;
    CMD_WREN   = 1'b0;
    CMD_WRDATA = '0;
    ST_RDEN    = 1'b0;
    accept     = 1'b0;
    sample     = 1'b0;
    case (state_q)
      IDLE: begin
        REQ_READY = 1'b1;
        if (REQ_VALID) begin
          accept  = 1'b1;
          state_d = next_step(SEL, sel_hit, csw_hit, tar_hit, REQ_WRITE);
        end
      end
      SEL, CSW, TAR, DRW, RDBUF: begin
        CMD_WRDATA = cmd_word;
        if (!CMD_WRFULL) begin
          CMD_WREN = 1'b1;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        // A pop is followed by one sample cycle; never pop again while a sample is pending.
        if (pend_q) begin
          sample  = 1'b1;
          state_d = stat_ok ? next_step(state_t'(step_q + 3'd1), sel_hit, csw_hit, tar_hit,
                                        req_write_q)
                            : RESP;
        end else if (!ST_RDEMPTY) begin
          ST_RDEN = 1'b1;
        end
      end
      RESP: begin
        RSP_VALID = 1'b1;
        if (RSP_READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      step_q      <= IDLE;
      pend_q      <= 1'b0;
      req_write_q <= 1'b0;
      req_apsel_q <= '0;
      req_size_q  <= '0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      sel_v       <= 1'b0;
      csw_v       <= 1'b0;
      tar_v       <= 1'b0;
      sel_ap      <= '0;
      csw_sz      <= '0;
      tar         <= '0;
      rsp_rdata_q <= '0;
      rsp_stat_q  <= '0;
    end else begin
      if (accept) begin
        req_write_q <= REQ_WRITE;
        req_apsel_q <= REQ_APSEL;
        req_size_q  <= REQ_SIZE;
        req_addr_q  <= REQ_ADDR;
        req_wdata_q <= REQ_WDATA;
        rsp_rdata_q <= '0;
      end
      if (CMD_WREN) step_q <= state_q;
      if (ST_RDEN)  pend_q <= 1'b1;
      if (sample) begin
        pend_q     <= 1'b0;
        rsp_stat_q <= ST_RDDATA[2:0];
        if (stat_ok) begin
          // DRW read data is the stale posted value; only RDBUF carries the real word.
          case (step_q)
            SEL:     begin sel_v <= 1'b1; sel_ap <= req_apsel_q; end
            CSW:     begin csw_v <= 1'b1; csw_sz <= req_size_q; end
            TAR:     begin tar_v <= 1'b1; tar <= req_addr_q; end
            RDBUF:   rsp_rdata_q <= ST_RDDATA[34:3];
            default: ;
          endcase
        end else begin
          sel_v       <= 1'b0;
          csw_v       <= 1'b0;
          tar_v       <= 1'b0;
          rsp_rdata_q <= '0;
        end
      end
    end
  end

endmodule
